local_packet_injector: RTL and testbench

// - Transmit-side network interface for a router's local port: packetises core requests into 17-bit flits.
// - Drives the router's local_data_i and obeys its local_full_o back-pressure.
// - Sits between a processing core and the router. It is the sender for the router's local input buffer and credit counter.

---
 rtl/local_packet_injector.sv | 157 +++++++++++++++
 tb/tb_local_packet_injector.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/local_packet_injector.sv
// local_packet_injector: turns core packet requests plus queued payload words into
// 17-bit router flits. Optional INJECTOR_STATS_EN adds pkt_cnt_o/stall_cnt_o.
// Ports:
//   clk, rst (async, active-low)
//   req_valid_i/req_dest_i/req_len_i/req_ready_o  packet request handshake
//   pay_valid_i/pay_data_i/pay_ready_o            payload FIFO write handshake
//   local_full_i                                  router back-pressure
//   local_data_o                                  registered flit: [16]=valid, [15:14]=type, [13:0]=payload
//   busy_o                                        packet in progress
module local_packet_injector #(
  parameter logic [3:0] ROUTER_ID  = 4'd1,
  parameter int         FIFO_DEPTH = 8,
  parameter int         MAX_LEN    = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_i,
  input  logic [3:0]  req_dest_i,
  input  logic [3:0]  req_len_i,
  output logic        req_ready_o,
  input  logic        pay_valid_i,
  input  logic [13:0] pay_data_i,
  output logic        pay_ready_o,
  input  logic        local_full_i,
  output logic [16:0] local_data_o,
  output logic        busy_o
`ifdef INJECTOR_STATS_EN
  ,
  output logic [15:0] pkt_cnt_o,
  output logic [15:0] stall_cnt_o
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [3:0] MAX_C = 4'(MAX_LEN);

  typedef enum logic [1:0] {
    IDLE,
    HEAD,
    BODY
  } state_t;

  state_t state_q, state_d;

  logic [13:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;

  logic        ready_en;
  logic [3:0]  dest_q, len_q, body_q;
  logic [3:0]  len_in;
  logic [16:0] flit_d;
  logic        accept, push, pop;
  logic        empty, full, last;

  assign empty  = (count == '0);
  assign full   = (count == DEPTH_C);
  assign last   = (body_q == len_q - 4'd1);
  assign len_in = (req_len_i > MAX_C) ? MAX_C : req_len_i;

  // ready_en holds both ready outputs low until the first edge after reset.
  assign req_ready_o = ready_en && (state_q == IDLE);
  // A pop in this cycle frees a slot, so a full FIFO can still take a word.
  assign pay_ready_o = ready_en && (!full || pop);
  assign push        = pay_valid_i && pay_ready_o;
  assign busy_o      = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    flit_d  = '0;
    accept  = 1'b0;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid_i && ready_en) begin
          accept  = 1'b1;
          state_d = HEAD;
        end
      end
      HEAD: begin
        if (!local_full_i) begin
          flit_d = {1'b1,
                    (len_q == 4'd0) ? 2'b11 : 2'b01,
                    dest_q, ROUTER_ID, len_q, 2'b00};
          state_d = (len_q == 4'd0) ? IDLE : BODY;
        end
      end
      BODY: begin
        if (!local_full_i && !empty) begin
          pop    = 1'b1;
          flit_d = {1'b1,
                    last ? 2'b10 : 2'b00,
                    mem[rd_ptr]};
          if (last) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      ready_en     <= 1'b0;
      dest_q       <= '0;
      len_q        <= '0;
      body_q       <= '0;
      local_data_o <= '0;
    end else begin
      state_q      <= state_d;
      ready_en     <= 1'b1;
      local_data_o <= flit_d;
      if (accept) begin
        dest_q <= req_dest_i;
        len_q  <= len_in;
        body_q <= '0;
      end else if (pop) begin
        body_q <= body_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop) count <= count + CW'(1);
      else if (!push && pop) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= pay_data_i;
  end

`ifdef INJECTOR_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pkt_cnt_o   <= '0;
      stall_cnt_o <= '0;
    end else begin
      // Types 10 and 11 both close a packet and share bit 15.
      if (flit_d[16] && flit_d[15] && pkt_cnt_o != 16'hFFFF)
        pkt_cnt_o <= pkt_cnt_o + 16'd1;
      if (busy_o && !flit_d[16] && stall_cnt_o != 16'hFFFF)
        stall_cnt_o <= stall_cnt_o + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_local_packet_injector.sv
// tb_local_packet_injector: directed and random stimulus for local_packet_injector,
// checked against a packet-level model of the flit stream.
module tb_local_packet_injector;

  localparam int         DEPTH = 8;
  localparam int         MAXL  = 12;
  localparam logic [3:0] RID   = 4'd1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic [3:0]  req_dest = '0;
  logic [3:0]  req_len = '0;
  logic        req_ready_o;
  logic        pay_valid = 1'b0;
  logic [13:0] pay_data = '0;
  logic        pay_ready_o;
  logic        local_full = 1'b0;
  logic [16:0] local_data_o;
  logic        busy_o;
`ifdef INJECTOR_STATS_EN
  logic [15:0] pkt_cnt_o;
  logic [15:0] stall_cnt_o;
`endif

  always #5 clk = ~clk;

  local_packet_injector #(
    .ROUTER_ID (RID),
    .FIFO_DEPTH(DEPTH),
    .MAX_LEN   (MAXL)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid_i (req_valid),
    .req_dest_i  (req_dest),
    .req_len_i   (req_len),
    .req_ready_o (req_ready_o),
    .pay_valid_i (pay_valid),
    .pay_data_i  (pay_data),
    .pay_ready_o (pay_ready_o),
    .local_full_i(local_full),
    .local_data_o(local_data_o),
    .busy_o      (busy_o)
`ifdef INJECTOR_STATS_EN
    ,
    .pkt_cnt_o   (pkt_cnt_o),
    .stall_cnt_o (stall_cnt_o)
`endif
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [16:0] head_flit(input logic [3:0] d,
                                            input logic [3:0] l);
    return {1'b1, (l == 4'd0) ? 2'b11 : 2'b01, d, RID, l, 2'b00};
  endfunction

  // Packet-level model: one packet in flight at most, payload words in order.
  bit          mon_en = 1'b0;
  bit          in_pkt = 1'b0;
  bit          head_pend = 1'b0;
  bit          prev_full = 1'b0;
  bit          busy_prev = 1'b0;
  logic [3:0]  m_dest = '0;
  logic [3:0]  m_len = '0;
  logic [3:0]  m_rem = '0;
  logic [13:0] words[$];
  logic [16:0] m_f, m_e;
  int          m_pkts = 0;
  int          m_stalls = 0;

  always @(negedge clk) begin
    if (mon_en) begin
      m_f = local_data_o;
      if (busy_prev && m_f == '0) m_stalls++;
      if (m_f != '0) begin
        check("flit_after_full", 32'(prev_full), 32'd0);
        m_e = '0;
        if (in_pkt && head_pend) begin
          m_e = head_flit(m_dest, m_len);
          head_pend = 1'b0;
          m_rem = m_len;
          if (m_len == 4'd0) in_pkt = 1'b0;
        end else if (in_pkt && words.size() > 0) begin
          m_e = {1'b1, (m_rem == 4'd1) ? 2'b10 : 2'b00, words.pop_front()};
          m_rem = m_rem - 4'd1;
          if (m_rem == 4'd0) in_pkt = 1'b0;
        end
        if (m_e[16] && m_e[15]) m_pkts++;
        check("flit_stream", 32'(m_f), 32'(m_e));
      end
      check("busy", 32'(busy_o), 32'(in_pkt));
      check("req_ready", 32'(req_ready_o), 32'(!in_pkt));
      if (words.size() < DEPTH)
        check("pay_ready", 32'(pay_ready_o), 32'd1);
      else if (local_full)
        check("pay_ready_full", 32'(pay_ready_o), 32'd0);
      if (req_valid && !in_pkt) begin
        in_pkt = 1'b1;
        head_pend = 1'b1;
        m_dest = req_dest;
        m_len = (req_len > 4'(MAXL)) ? 4'(MAXL) : req_len;
      end
      if (pay_valid && pay_ready_o) words.push_back(pay_data);
      prev_full = local_full;
      busy_prev = in_pkt;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic see(input string tag, input logic [16:0] exp);
    check(tag, 32'(local_data_o), 32'(exp));
  endtask

  task automatic push_word(input logic [13:0] w);
    pay_valid = 1'b1;
    pay_data = w;
    tick();
    pay_valid = 1'b0;
  endtask

  task automatic request(input logic [3:0] d, input logic [3:0] l);
    req_valid = 1'b1;
    req_dest = d;
    req_len = l;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    rst = 1'b0;
    req_valid = 1'b0;
    pay_valid = 1'b0;
    local_full = 1'b0;
    #1;
    check("rst_data", 32'(local_data_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_req_ready", 32'(req_ready_o), 32'd0);
    check("rst_pay_ready", 32'(pay_ready_o), 32'd0);
    tick();
    rst = 1'b1;
    #1;
    check("rel_req_ready", 32'(req_ready_o), 32'd0);
    check("rel_pay_ready", 32'(pay_ready_o), 32'd0);
    tick();
    check("up_req_ready", 32'(req_ready_o), 32'd1);
    check("up_pay_ready", 32'(pay_ready_o), 32'd1);
    in_pkt = 1'b0;
    head_pend = 1'b0;
    prev_full = 1'b0;
    busy_prev = 1'b0;
    words.delete();
    m_pkts = 0;
    m_stalls = 0;
    mon_en = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    do_reset();

    request(4'h3, 4'h0);
    check("single_busy", 32'(busy_o), 32'd1);
    check("single_rdy", 32'(req_ready_o), 32'd0);
    tick();
    see("single_head", {1'b1, 2'b11, 4'h3, 4'h1, 4'h0, 2'b00});
    check("single_idle", 32'(busy_o), 32'd0);
    tick();
    see("single_gap", '0);

    push_word(14'h0AA);
    push_word(14'h0BB);
    request(4'h2, 4'h2);
    tick();
    see("three_head", head_flit(4'h2, 4'h2));
    tick();
    see("three_body", {1'b1, 2'b00, 14'h0AA});
    tick();
    see("three_tail", {1'b1, 2'b10, 14'h0BB});
    tick();
    see("three_gap", '0);

    push_word(14'h111);
    push_word(14'h222);
    request(4'h4, 4'h2);
    tick();
    see("bp_head", head_flit(4'h4, 4'h2));
    local_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      see("bp_hold", '0);
    end
    local_full = 1'b0;
    tick();
    see("bp_resume", {1'b1, 2'b00, 14'h111});
    tick();
    see("bp_tail", {1'b1, 2'b10, 14'h222});
    tick();
    check("bp_idle", 32'(busy_o), 32'd0);

    push_word(14'h301);
    request(4'h6, 4'h3);
    tick();
    see("starve_head", head_flit(4'h6, 4'h3));
    tick();
    see("starve_body1", {1'b1, 2'b00, 14'h301});
    for (int i = 0; i < 3; i++) begin
      tick();
      see("starve_hold", '0);
    end
    pay_valid = 1'b1;
    pay_data = 14'h302;
    tick();
    see("starve_wait", '0);
    pay_data = 14'h303;
    tick();
    see("starve_body2", {1'b1, 2'b00, 14'h302});
    pay_valid = 1'b0;
    tick();
    see("starve_tail", {1'b1, 2'b10, 14'h303});
    tick();
    check("starve_idle", 32'(busy_o), 32'd0);

    pay_valid = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      pay_data = 14'h400 + 14'(i);
      tick();
    end
    pay_data = 14'h4FF;
    #1;
    check("full_ready", 32'(pay_ready_o), 32'd0);
    tick();
    pay_valid = 1'b0;
    request(4'h5, 4'd9);
    tick();
    see("full_head", head_flit(4'h5, 4'd9));
    pay_valid = 1'b1;
    pay_data = 14'h408;
    #1;
    check("full_pushpop_ready", 32'(pay_ready_o), 32'd1);
    tick();
    see("full_body0", {1'b1, 2'b00, 14'h400});
    pay_valid = 1'b0;
    local_full = 1'b1;
    #1;
    check("full_count_kept", 32'(pay_ready_o), 32'd0);
    tick();
    see("full_hold", '0);
    local_full = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      see("full_body", {1'b1, (k == 8) ? 2'b10 : 2'b00, 14'h400 + 14'(k)});
    end
    tick();
    check("full_idle", 32'(busy_o), 32'd0);

`ifdef INJECTOR_STATS_EN
    check("stats_pkts_dir", 32'(pkt_cnt_o), 32'd5);
    check("stats_stalls_dir", 32'(stall_cnt_o), 32'd8);
`endif

    push_word(14'h0C1);
    push_word(14'h0C2);
    request(4'h8, 4'h4);
    tick();
    see("rstmid_head", head_flit(4'h8, 4'h4));
    tick();
    see("rstmid_body", {1'b1, 2'b00, 14'h0C1});
    do_reset();
    request(4'h7, 4'h1);
    tick();
    see("fresh_head", head_flit(4'h7, 4'h1));
    tick();
    see("fresh_flushed", '0);
    push_word(14'h555);
    see("fresh_wait", '0);
    tick();
    see("fresh_tail", {1'b1, 2'b10, 14'h555});

    for (int c = 0; c < 3000; c++) begin
      req_valid = ($urandom_range(3) == 0);
      req_dest = 4'($urandom);
      req_len = 4'($urandom);
      pay_valid = ($urandom_range(1) == 1);
      pay_data = 14'($urandom);
      local_full = ($urandom_range(3) == 0);
      tick();
    end
    req_valid = 1'b0;
    local_full = 1'b0;
    for (int c = 0; c < 400 && in_pkt; c++) begin
      pay_valid = 1'b1;
      pay_data = 14'($urandom);
      tick();
    end
    pay_valid = 1'b0;
    tick();
    tick();
    check("drain_idle", 32'(busy_o), 32'd0);
    check("drain_model", 32'(in_pkt), 32'd0);

`ifdef INJECTOR_STATS_EN
    check("stats_pkts", 32'(pkt_cnt_o), 32'(m_pkts));
    check("stats_stalls", 32'(stall_cnt_o), 32'(m_stalls));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
